// File: rtl/mvm_pkg.sv
// Shared state type and sizing helpers for the UART matrix-vector-multiply controller.
package mvm_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2,
    SEND = 2'd3
  } mvm_state_t;

  localparam int unsigned R_DEF = 2;
  localparam int unsigned C_DEF = 2;

  // N_K: number of K matrix bytes in a frame
  function automatic int unsigned f_n_k(input int unsigned r, input int unsigned c);
    return r * c;
  endfunction

  // N_FRAME: total bytes received per frame (K then x)
  function automatic int unsigned f_n_frame(input int unsigned r, input int unsigned c);
    return r * c + c;
  endfunction

  // Index counter width; never narrower than one bit
  function automatic int unsigned f_cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvm_y_serializer.sv
// Holds the captured y result and streams it out one sign-extended byte per tx handshake.
module mvm_y_serializer
  import mvm_pkg::*;
#(
  parameter int unsigned R       = R_DEF,
  parameter int unsigned W_Y_OUT = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_capture,
  input  logic [R*W_Y_OUT-1:0]   i_y_flat,
  input  logic                   i_ready,
  output logic                   o_valid,
  output logic [7:0]             o_data,
  output logic                   o_last_c
);

  localparam int unsigned W_W = f_cnt_w(R);

  logic [R*W_Y_OUT-1:0] r_y;
  logic [W_W-1:0]       r_w;
  logic                 r_valid;
  logic [7:0]           r_data;
  logic                 w_fire;
  logic                 w_last;
  logic [W_W-1:0]       w_next;

  function automatic logic [7:0] f_sext(input logic [W_Y_OUT-1:0] v);
    logic signed [W_Y_OUT-1:0] s;
    s = $signed(v);
    return 8'(s);
  endfunction

  function automatic logic [7:0] f_word(input logic [R*W_Y_OUT-1:0] y, input logic [W_W-1:0] idx);
    logic [7:0] v;
    v = '0;
    for (int unsigned r = 0; r < R; r++) begin
      if (idx == W_W'(r)) v = f_sext(y[r*W_Y_OUT +: W_Y_OUT]);
    end
    return v;
  endfunction

  assign w_fire = r_valid && i_ready;
  assign w_last = w_fire && (r_w == W_W'(R - 1));
  assign w_next = r_w + W_W'(1);

  // Byte presented in m_data is always the pre-computed word r_w
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_y     <= '0;
      r_w     <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_capture) begin
      r_y     <= i_y_flat;
      r_w     <= '0;
      r_valid <= 1'b1;
      r_data  <= f_word(i_y_flat, W_W'(0));
    end else if (w_fire) begin
      if (w_last) begin
        r_w     <= '0;
        r_valid <= 1'b0;
        r_data  <= '0;
      end else begin
        r_w    <= w_next;
        r_data <= f_word(r_y, w_next);
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_data   = r_data;
  assign o_last_c = w_last;

endmodule

// File: rtl/mvm_uart_ctrl.sv
// Frame sequencer between UART rx/tx and the MVM engine: load K and x, start, await done, send y.
// Optional inter-byte idle timeout enabled by defining MVM_CTRL_TIMEOUT_EN.
module mvm_uart_ctrl
  import mvm_pkg::*;
#(
  parameter int unsigned R              = R_DEF,
  parameter int unsigned C              = C_DEF,
  parameter int unsigned W_K            = 2,
  parameter int unsigned W_X            = 4,
  parameter int unsigned W_Y_OUT        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic [R*C*W_K-1:0]   k_flat,
  output logic [C*W_X-1:0]     x_flat,
  output logic                 start,
  input  logic                 done,
  input  logic [R*W_Y_OUT-1:0] y_flat,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [7:0]           m_data,
  output logic                 err_overrun,
  output logic                 err_timeout
);

  localparam int unsigned N_K     = f_n_k(R, C);
  localparam int unsigned N_FRAME = f_n_frame(R, C);
  localparam int unsigned CNT_W   = f_cnt_w(N_FRAME);

  mvm_state_t          r_state;
  logic [CNT_W-1:0]    r_n;
  logic                r_s_ready;
  logic                r_start;
  logic                r_err_overrun;
  logic [N_K*W_K-1:0]  r_k;
  logic [C*W_X-1:0]    r_x;

  logic                w_accept;
  logic                w_capture;
  logic                w_last_sent;
  logic                w_expire;
  logic                w_last_byte;
  logic [CNT_W-1:0]    w_idx;
  logic                w_unused_sdata;

  assign w_accept       = s_valid && r_s_ready;
  assign w_capture      = (r_state == WAIT) && done;
  // A byte landing on the expiry cycle starts a fresh frame at index 0
  assign w_idx          = w_expire ? '0 : r_n;
  assign w_last_byte    = (w_idx == CNT_W'(N_FRAME - 1));
  assign w_unused_sdata = ^s_data;

`ifdef MVM_CTRL_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] r_idle;
  logic              r_err_timeout;

  assign w_expire = (r_state == LOAD) && (r_n != '0) && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle counter only runs while a partial frame is pending
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle        <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_expire) r_err_timeout <= 1'b1;
      if (w_accept || w_expire || (r_state != LOAD) || (r_n == '0)) r_idle <= '0;
      else r_idle <= r_idle + IDLE_W'(1);
    end
  end

  assign err_timeout = r_err_timeout;
`else
  logic w_unused_timeout;

  assign w_expire         = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign err_timeout      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= LOAD;
      r_n           <= '0;
      r_s_ready     <= 1'b1;
      r_start       <= 1'b0;
      r_err_overrun <= 1'b0;
      r_k           <= '0;
      r_x           <= '0;
    end else begin
      if (s_valid && !r_s_ready) r_err_overrun <= 1'b1;
      case (r_state)
        LOAD: begin
          if (w_accept) begin
            for (int unsigned i = 0; i < N_K; i++) begin
              if (w_idx == CNT_W'(i)) r_k[i*W_K +: W_K] <= s_data[W_K-1:0];
            end
            for (int unsigned j = 0; j < C; j++) begin
              if (w_idx == CNT_W'(N_K + j)) r_x[j*W_X +: W_X] <= s_data[W_X-1:0];
            end
            if (w_last_byte) begin
              r_n       <= '0;
              r_state   <= RUN;
              r_start   <= 1'b1;
              r_s_ready <= 1'b0;
            end else begin
              r_n <= w_idx + CNT_W'(1);
            end
          end else if (w_expire) begin
            r_n <= '0;
          end
        end
        RUN: begin
          r_start <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: begin
          if (done) r_state <= SEND;
        end
        SEND: begin
          if (w_last_sent) begin
            r_state   <= LOAD;
            r_s_ready <= 1'b1;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  mvm_y_serializer #(
    .R       (R),
    .W_Y_OUT (W_Y_OUT)
  ) u_y_serializer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_capture (w_capture),
    .i_y_flat  (y_flat),
    .i_ready   (m_ready),
    .o_valid   (m_valid),
    .o_data    (m_data),
    .o_last_c  (w_last_sent)
  );

  assign s_ready     = r_s_ready;
  assign start       = r_start;
  assign k_flat      = r_k;
  assign x_flat      = r_x;
  assign err_overrun = r_err_overrun;

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Directed bench for mvm_uart_ctrl: default build plus a W_Y_OUT=4 copy in lockstep.
module tb_mvm_uart_ctrl;

`ifdef MVM_CTRL_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        done = 1'b0;
  logic [15:0] y_flat = 16'h0000;
  logic [7:0]  y_flat4 = 8'h00;
  logic        m_ready = 1'b0;

  logic        s_ready, start, m_valid, err_overrun, err_timeout;
  logic [7:0]  k_flat, x_flat, m_data;
  logic        s_ready4, start4, m_valid4, err_overrun4, err_timeout4;
  logic [7:0]  k_flat4, x_flat4, m_data4;

  always #5 clk = ~clk;

  mvm_uart_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .k_flat(k_flat), .x_flat(x_flat), .start(start), .done(done), .y_flat(y_flat),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .err_overrun(err_overrun), .err_timeout(err_timeout)
  );

  mvm_uart_ctrl #(.W_Y_OUT(4), .TIMEOUT_CYCLES(TO)) dut4 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready4),
    .k_flat(k_flat4), .x_flat(x_flat4), .start(start4), .done(done), .y_flat(y_flat4),
    .m_valid(m_valid4), .m_ready(m_ready), .m_data(m_data4),
    .err_overrun(err_overrun4), .err_timeout(err_timeout4)
  );

  typedef struct {
    logic        sv;
    logic [7:0]  sd;
    logic        dn;
    logic [15:0] y;
    logic [7:0]  y4;
    logic        mr;
    logic        e_srdy;
    logic        e_st;
    logic        e_mv;
    logic [7:0]  e_md;
    logic [7:0]  e_md4;
    logic [7:0]  e_k;
    logic [7:0]  e_x;
    logic        e_ovr;
  } vec_t;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  function automatic vec_t mk(input logic sv, input logic [7:0] sd, input logic dn,
                              input logic [15:0] y, input logic [7:0] y4, input logic mr,
                              input logic e_srdy, input logic e_st, input logic e_mv,
                              input logic [7:0] e_md, input logic [7:0] e_md4,
                              input logic [7:0] e_k, input logic [7:0] e_x, input logic e_ovr);
    vec_t v;
    v.sv = sv; v.sd = sd; v.dn = dn; v.y = y; v.y4 = y4; v.mr = mr;
    v.e_srdy = e_srdy; v.e_st = e_st; v.e_mv = e_mv; v.e_md = e_md; v.e_md4 = e_md4;
    v.e_k = e_k; v.e_x = e_x; v.e_ovr = e_ovr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    step();
    s_valid = 1'b0;
  endtask

  // Both instances share every observable except m_data encoding
  task automatic chk_outs(input string tag, input logic e_srdy, input logic e_st, input logic e_mv,
                          input logic [7:0] e_md, input logic [7:0] e_md4,
                          input logic [7:0] e_k, input logic [7:0] e_x, input logic e_ovr);
    chk({tag, ".s_ready"},      32'(s_ready),      32'(e_srdy));
    chk({tag, ".start"},        32'(start),        32'(e_st));
    chk({tag, ".m_valid"},      32'(m_valid),      32'(e_mv));
    chk({tag, ".m_data"},       32'(m_data),       32'(e_md));
    chk({tag, ".k_flat"},       32'(k_flat),       32'(e_k));
    chk({tag, ".x_flat"},       32'(x_flat),       32'(e_x));
    chk({tag, ".err_overrun"},  32'(err_overrun),  32'(e_ovr));
    chk({tag, ".s_ready4"},     32'(s_ready4),     32'(e_srdy));
    chk({tag, ".start4"},       32'(start4),       32'(e_st));
    chk({tag, ".m_valid4"},     32'(m_valid4),     32'(e_mv));
    chk({tag, ".m_data4"},      32'(m_data4),      32'(e_md4));
    chk({tag, ".k_flat4"},      32'(k_flat4),      32'(e_k));
    chk({tag, ".x_flat4"},      32'(x_flat4),      32'(e_x));
    chk({tag, ".err_overrun4"}, 32'(err_overrun4), 32'(e_ovr));
  endtask

  task automatic chk_reset(input string tag);
    chk_outs(tag, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    chk({tag, ".err_timeout"},  32'(err_timeout),  32'd0);
    chk({tag, ".err_timeout4"}, 32'(err_timeout4), 32'd0);
  endtask

  vec_t        vecs [12];
  logic [7:0]  fr [6];

  initial begin
    //            sv  sd     dn  y        y4     mr | srdy st  mv  md     md4    k      x      ovr
    vecs[0]  = mk(1, 8'h01, 0, 16'h0000, 8'h00, 0,   1,  0,  0, 8'h00, 8'h00, 8'h01, 8'h00, 0);
    vecs[1]  = mk(1, 8'h02, 0, 16'h0000, 8'h00, 0,   1,  0,  0, 8'h00, 8'h00, 8'h09, 8'h00, 0);
    vecs[2]  = mk(1, 8'h03, 0, 16'h0000, 8'h00, 0,   1,  0,  0, 8'h00, 8'h00, 8'h39, 8'h00, 0);
    vecs[3]  = mk(1, 8'h01, 0, 16'h0000, 8'h00, 0,   1,  0,  0, 8'h00, 8'h00, 8'h79, 8'h00, 0);
    vecs[4]  = mk(1, 8'h05, 0, 16'h0000, 8'h00, 0,   1,  0,  0, 8'h00, 8'h00, 8'h79, 8'h05, 0);
    vecs[5]  = mk(1, 8'h07, 0, 16'h0000, 8'h00, 0,   0,  1,  0, 8'h00, 8'h00, 8'h79, 8'h75, 0);
    vecs[6]  = mk(0, 8'h00, 0, 16'h0000, 8'h00, 0,   0,  0,  0, 8'h00, 8'h00, 8'h79, 8'h75, 0);
    vecs[7]  = mk(1, 8'hAA, 0, 16'h0000, 8'h00, 0,   0,  0,  0, 8'h00, 8'h00, 8'h79, 8'h75, 1);
    vecs[8]  = mk(0, 8'h00, 1, 16'hF311, 8'h5A, 1,   0,  0,  1, 8'h11, 8'hFA, 8'h79, 8'h75, 1);
    vecs[9]  = mk(0, 8'h00, 0, 16'h0000, 8'h00, 1,   0,  0,  1, 8'hF3, 8'h05, 8'h79, 8'h75, 1);
    vecs[10] = mk(0, 8'h00, 0, 16'h0000, 8'h00, 1,   1,  0,  0, 8'h00, 8'h00, 8'h79, 8'h75, 1);
    vecs[11] = mk(0, 8'h00, 1, 16'hF311, 8'h5A, 1,   1,  0,  0, 8'h00, 8'h00, 8'h79, 8'h75, 1);

    step();
    step();
    chk_reset("reset");
    rst = 1'b0;

    // Table: first frame, overrun in WAIT, done, two-byte send, done ignored in LOAD
    for (int i = 0; i < 12; i++) begin
      s_valid = vecs[i].sv;
      s_data  = vecs[i].sd;
      done    = vecs[i].dn;
      y_flat  = vecs[i].y;
      y_flat4 = vecs[i].y4;
      m_ready = vecs[i].mr;
      step();
      chk_outs($sformatf("v%0d", i), vecs[i].e_srdy, vecs[i].e_st, vecs[i].e_mv, vecs[i].e_md,
               vecs[i].e_md4, vecs[i].e_k, vecs[i].e_x, vecs[i].e_ovr);
    end
    s_valid = 1'b0;
    done    = 1'b0;
    m_ready = 1'b0;

    // Second frame after overrun, upper byte bits ignored, tx backpressure
    fr = '{8'h03, 8'hFE, 8'h02, 8'h01, 8'h3F, 8'h08};
    for (int i = 0; i < 6; i++) begin
      send_byte(fr[i]);
      if (i < 5) chk("f2.start_early", 32'(start), 32'd0);
    end
    chk_outs("f2.loaded", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h6B, 8'h8F, 1'b1);
    step();
    chk("f2.start_single", 32'(start), 32'd0);
    step();
    step();
    done = 1'b1; y_flat = 16'h7F80; y_flat4 = 8'h38;
    step();
    done = 1'b0;
    chk_outs("f2.word0", 1'b0, 1'b0, 1'b1, 8'h80, 8'hF8, 8'h6B, 8'h8F, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_outs($sformatf("f2.hold%0d", i), 1'b0, 1'b0, 1'b1, 8'h80, 8'hF8, 8'h6B, 8'h8F, 1'b1);
    end
    m_ready = 1'b1;
    step();
    chk_outs("f2.word1", 1'b0, 1'b0, 1'b1, 8'h7F, 8'h03, 8'h6B, 8'h8F, 1'b1);
    step();
    chk_outs("f2.back_to_load", 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h6B, 8'h8F, 1'b1);
    m_ready = 1'b0;

`ifdef MVM_CTRL_TIMEOUT_EN
    // Abandoned partial frame, then a full frame from index 0
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    repeat (15) step();
    chk("to.not_yet", 32'(err_timeout), 32'd0);
    step();
    chk("to.expired", 32'(err_timeout), 32'd1);
    chk("to.expired4", 32'(err_timeout4), 32'd1);
    chk("to.partial_k", 32'(k_flat), 32'h79);
    fr = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h03};
    for (int i = 0; i < 6; i++) begin
      send_byte(fr[i]);
      if (i < 5) chk("to.start_early", 32'(start), 32'd0);
    end
    chk("to.start", 32'(start), 32'd1);
    chk("to.k", 32'(k_flat), 32'h55);
    chk("to.x", 32'(x_flat), 32'h32);
    chk("to.sticky", 32'(err_timeout), 32'd1);
`endif

    // Reset mid-frame discards the partial frame and takes priority over a byte
    rst = 1'b1;
    step();
    rst = 1'b0;
    send_byte(8'h02);
    send_byte(8'h03);
    chk("rm.partial_k", 32'(k_flat), 32'h0E);
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hFF;
    step();
    s_valid = 1'b0;
    chk_reset("rm.reset");
    rst = 1'b0;
    fr = '{8'h03, 8'h03, 8'h03, 8'h03, 8'h0A, 8'h0B};
    for (int i = 0; i < 6; i++) send_byte(fr[i]);
    chk_outs("rm.frame", 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'hFF, 8'hBA, 1'b0);

    // Reset during SEND drops the pending result
    step();
    step();
    done = 1'b1; y_flat = 16'h1234; y_flat4 = 8'h12;
    step();
    done = 1'b0;
    chk_outs("rs.word0", 1'b0, 1'b0, 1'b1, 8'h34, 8'h02, 8'hFF, 8'hBA, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset("rs.reset");
    step();
    chk_reset("rs.idle");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mvm_uart_ctrl.md
# mvm_uart_ctrl

Sequencing controller between the UART byte receiver/transmitter and the matrix-vector multiply engine in the UART MVM system. It collects a K matrix and an x vector from the received byte stream and holds them stable for the engine. It then issues a one-cycle start, waits for the engine's done, and streams the R result words back out as bytes. One frame is one multiply: R*C K bytes, then C x bytes in, then R y bytes out.

## Interface
- R, 2, matrix rows / result words
- C, 2, matrix columns / x elements
- W_K, 2, K element width (1..8)
- W_X, 4, x element width (1..8)
- W_Y_OUT, 8, y word width (1..8)
- TIMEOUT_CYCLES, 4096, inter-byte idle limit (only with MVM_CTRL_TIMEOUT_EN)
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  received byte strobe from UART rx (one cycle per byte)
- s_data  in  8  received byte
- s_ready  out  1  controller accepting bytes
- k_flat  out  R*C*W_K  K matrix, row-major; element i at [i*W_K +: W_K]
- x_flat  out  C*W_X  x vector; element j at [j*W_X +: W_X]
- start  out  1  one-cycle engine start pulse
- done  in  1  engine completion pulse; y_flat valid in same cycle
- y_flat  in  R*W_Y_OUT  result; word r at [r*W_Y_OUT +: W_Y_OUT]
- m_valid  out  1  tx byte valid
- m_ready  in  1  UART tx ready
- m_data  out  8  tx byte
- err_overrun  out  1  sticky: byte arrived while s_ready=0
- err_timeout  out  1  sticky: frame abandoned on timeout

## Operation
- States: LOAD, RUN, WAIT, SEND.
- LOAD: s_ready=1. Byte counter n runs 0..R*C+C-1.
  - n<R*C: byte[W_K-1:0] goes to K element n.
  - Otherwise: byte[W_X-1:0] goes to x element n-R*C.
  - Upper byte bits are ignored.
  - On the last byte, n clears and the FSM goes to RUN.
- RUN: start=1 for exactly one cycle, then WAIT.
- WAIT: on done, y_flat is captured into an internal y register, word index w=0, then SEND.
- SEND: m_valid=1, m_data=y word w sign-extended to 8 bits.
  - On m_valid&&m_ready, w increments.
  - After word R-1 is accepted, the FSM returns to LOAD.
- k_flat/x_flat are registers. They are written only in LOAD and stay stable through RUN/WAIT/SEND.
- done outside WAIT is ignored.
- s_valid while s_ready=0: the byte is dropped and err_overrun is set.
- Error flags clear only on rst.

## Timing
- Reset values: state LOAD, n=0, w=0.
- Outputs at reset: s_ready=1, start=0, m_valid=0, m_data=0, k_flat=0, x_flat=0, err_overrun=0, err_timeout=0.
- rst mid-frame discards the partial frame and any pending y. It takes priority over every event.
- Last load byte accepted at cycle t: start=1 at t+1; s_ready=0 from t+1.
- done at cycle d: m_valid=1 with word 0 at d+1.
- Final tx handshake at cycle e: s_ready=1 at e+1.
- m_data and m_valid hold stable while m_ready=0.
- Throughput: one byte per cycle accepted in LOAD, with no gaps required.

## Configuration
- MVM_CTRL_TIMEOUT_EN defined:
  - An idle counter runs in LOAD while n>0 and resets on each accepted byte.
  - When it reaches TIMEOUT_CYCLES: n clears to 0, err_timeout is set, k_flat/x_flat keep their partial contents.
  - A byte arriving in the same cycle as expiry counts as the first byte of a new frame (n becomes 1).
- Undefined: no counter, err_timeout tied 0, and a partial frame waits indefinitely.

## Structure
- Shared package mvm_pkg holds:
  - the state enum (LOAD/RUN/WAIT/SEND);
  - the derived constants N_K=R*C and N_FRAME=R*C+C;
  - the counter width function ($clog2 of N_FRAME).
- One sub-module, mvm_y_serializer, owns the y register, w, m_valid/m_data, and the sign extension. It is loaded by a capture strobe and reports a last-byte-sent pulse.

## Test plan
- Defaults; bytes 01,02,03,01,05,07 on consecutive cycles -> k_flat=0x79, x_flat=0x75, start single pulse the cycle after 07, s_ready low from then.
- In WAIT, done with y_flat=0xF311, m_ready=1 -> m_data 0x11 then 0xF3 on consecutive cycles, then s_ready=1.
- Same frame, m_ready held 0 for 5 cycles -> m_valid=1 and m_data=0x11 stable throughout; no byte skipped.
- W_Y_OUT=4, y word 0xA -> m_data=0xFA.
- s_valid pulse during WAIT -> err_overrun=1 sticky, k_flat unchanged; next frame still processes correctly.
- With MVM_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16: send 3 bytes, idle 16 cycles -> err_timeout=1, next 6 bytes form a full frame and start pulses; rst mid-frame -> all outputs return to reset values.
